// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS -> RAVENS event path: the packed
// event word layout, replay FSM states and late-drop counter helpers.
package dvs_ravens_pkg;

   localparam int DVS_X_ADDR_BITS       = 9;
   localparam int DVS_Y_ADDR_BITS       = 9;
   localparam int TIMESTAMP_US_BITS     = 48;
   localparam int EVENT_BITS            = DVS_X_ADDR_BITS + DVS_Y_ADDR_BITS + 1 + TIMESTAMP_US_BITS;
   localparam int CLK_PERIOD_US_DIVISOR = 1000;
   localparam int LATE_CNT_BITS         = 16;

   // x in the MSBs, then y, then polarity, timestamp in the LSBs
   typedef struct packed {
      logic [DVS_X_ADDR_BITS-1:0]   x;
      logic [DVS_Y_ADDR_BITS-1:0]   y;
      logic                         pol;
      logic [TIMESTAMP_US_BITS-1:0] ts;
   } dvs_event_t;

   typedef enum logic [1:0] {
      RPL_IDLE = 2'd0,
      RPL_WAIT = 2'd1,
      RPL_EMIT = 2'd2
   } replay_state_e;

   // Saturating increment for the dropped-late counter
   function automatic logic [LATE_CNT_BITS-1:0] late_cnt_sat_inc(input logic [LATE_CNT_BITS-1:0] cnt);
      late_cnt_sat_inc = (cnt == {LATE_CNT_BITS{1'b1}}) ? cnt : cnt + 1'b1;
   endfunction

endpackage

// File: rtl/dvs_event_replayer_fifo.sv
// dvs_event_fifo: small synchronous FIFO holding packed event words.
// Pointers carry one extra wrap bit so full/empty need no separate counter;
// DEPTH must be a power of two. Storage is not reset, only the pointers.
module dvs_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[AW-1:0]];

   // Pointer advance on accepted push/pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/dvs_event_replayer.sv
// dvs_event_replayer: buffers packed DVS events and replays each one on the
// out_* valid/ready port once the local microsecond time base reaches its
// timestamp. Events leave strictly in arrival order.
// Optional build macro DVS_LATE_DROP_EN: events already late on their first
// WAIT cycle are discarded and counted in late_count (saturating).
module dvs_event_replayer
   import dvs_ravens_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int US_DIVISOR = CLK_PERIOD_US_DIVISOR
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ts_start,
   input  logic [EVENT_BITS-1:0]        in_event,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [DVS_X_ADDR_BITS-1:0]   out_x,
   output logic [DVS_Y_ADDR_BITS-1:0]   out_y,
   output logic                         out_pol,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [TIMESTAMP_US_BITS-1:0] now_us,
   output logic [LATE_CNT_BITS-1:0]     late_count
);

   localparam int PRE_W = (US_DIVISOR > 1) ? $clog2(US_DIVISOR) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(US_DIVISOR - 1);

   replay_state_e                state_q, state_d;
   logic [PRE_W-1:0]             presc_q, presc_d;
   logic [TIMESTAMP_US_BITS-1:0] now_q, now_d;
   logic                         running_q, running_d;
   dvs_event_t                   hold_q, hold_d;
   logic [DVS_X_ADDR_BITS-1:0]   out_x_q, out_x_d;
   logic [DVS_Y_ADDR_BITS-1:0]   out_y_q, out_y_d;
   logic                         out_pol_q, out_pol_d;
   logic                         out_valid_q, out_valid_d;
`ifdef DVS_LATE_DROP_EN
   logic                         first_q, first_d;
   logic [LATE_CNT_BITS-1:0]     late_q, late_d;
`endif

   logic                  fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [EVENT_BITS-1:0] fifo_dout;

   assign in_ready  = !fifo_full && !rst;
   assign fifo_push = in_valid && in_ready;
   assign fifo_pop  = (state_q == RPL_IDLE) && !fifo_empty;

   dvs_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVENT_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .din   (in_event),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Time base and replay FSM next-state logic
   always_comb begin
      state_d     = state_q;
      presc_d     = presc_q;
      now_d       = now_q;
      running_d   = running_q;
      hold_d      = hold_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_pol_d   = out_pol_q;
      out_valid_d = out_valid_q;
`ifdef DVS_LATE_DROP_EN
      first_d     = first_q;
      late_d      = late_q;
`endif

      // ts_start restarts from zero even when already running
      if (ts_start) begin
         presc_d   = '0;
         now_d     = '0;
         running_d = 1'b1;
      end else if (running_q) begin
         if (presc_q == PRE_LAST) begin
            presc_d = '0;
            now_d   = now_q + 1'b1;
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end

      unique case (state_q)
         RPL_IDLE: begin
            if (!fifo_empty) begin
               hold_d  = dvs_event_t'(fifo_dout);
               state_d = RPL_WAIT;
`ifdef DVS_LATE_DROP_EN
               first_d = 1'b1;
`endif
            end
         end
         RPL_WAIT: begin
`ifdef DVS_LATE_DROP_EN
            first_d = 1'b0;
            if (first_q && running_q && (hold_q.ts < now_q)) begin
               late_d  = late_cnt_sat_inc(late_q);
               state_d = RPL_IDLE;
            end else
`endif
            if (running_q && (now_q >= hold_q.ts)) begin
               out_x_d     = hold_q.x;
               out_y_d     = hold_q.y;
               out_pol_d   = hold_q.pol;
               out_valid_d = 1'b1;
               state_d     = RPL_EMIT;
            end
         end
         RPL_EMIT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = RPL_IDLE;
            end
         end
         default: state_d = RPL_IDLE;
      endcase
   end

   // State registers; reset discards any held event and stops the time base
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= RPL_IDLE;
         presc_q     <= '0;
         now_q       <= '0;
         running_q   <= 1'b0;
         out_x_q     <= '0;
         out_y_q     <= '0;
         out_pol_q   <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef DVS_LATE_DROP_EN
         first_q     <= 1'b0;
         late_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         now_q       <= now_d;
         running_q   <= running_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_pol_q   <= out_pol_d;
         out_valid_q <= out_valid_d;
`ifdef DVS_LATE_DROP_EN
         first_q     <= first_d;
         late_q      <= late_d;
`endif
      end
   end

   // Hold register is pure data and is only meaningful outside IDLE
   always_ff @(posedge clk) begin
      hold_q <= hold_d;
   end

   assign out_x     = out_x_q;
   assign out_y     = out_y_q;
   assign out_pol   = out_pol_q;
   assign out_valid = out_valid_q;
   assign now_us    = now_q;
`ifdef DVS_LATE_DROP_EN
   assign late_count = late_q;
`else
   assign late_count = '0;
`endif

endmodule

// File: tb/tb_dvs_event_replayer.sv
// Testbench for dvs_event_replayer: directed steps plus a randomized burst,
// checked against a queue-based arrival-order model and an elapsed-cycle
// time model (now = elapsed cycles / US_DIVISOR since the last ts_start).
module tb_dvs_event_replayer;
   import dvs_ravens_pkg::*;

   localparam int US_DIV = CLK_PERIOD_US_DIVISOR;

   logic                         clk = 1'b0;
   logic                         rst;
   logic                         ts_start;
   logic [EVENT_BITS-1:0]        in_event;
   logic                         in_valid;
   logic                         in_ready;
   logic [DVS_X_ADDR_BITS-1:0]   out_x;
   logic [DVS_Y_ADDR_BITS-1:0]   out_y;
   logic                         out_pol;
   logic                         out_valid;
   logic                         out_ready;
   logic [TIMESTAMP_US_BITS-1:0] now_us;
   logic [LATE_CNT_BITS-1:0]     late_count;

   int         n_assert = 0;
   int         n_fail   = 0;
   longint     cyc      = 0;
   longint     start_cyc = 0;
   bit         rnd_en   = 1'b0;
   dvs_event_t exp_q[$];
   dvs_event_t mon_ev;

   dvs_event_replayer #(
      .FIFO_DEPTH (4),
      .US_DIVISOR (US_DIV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .ts_start   (ts_start),
      .in_event   (in_event),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_x      (out_x),
      .out_y      (out_y),
      .out_pol    (out_pol),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .now_us     (now_us),
      .late_count (late_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rnd_en) out_ready = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic samp();
      @(negedge clk);
   endtask

   function automatic logic [63:0] exp_now();
      return 64'((cyc - start_cyc) / US_DIV);
   endfunction

   task automatic pulse_ts_start();
      ts_start = 1'b1;
      tick(1);
      ts_start = 1'b0;
      start_cyc = cyc;
   endtask

   // Present one event and wait (bounded) for it to be accepted
   task automatic push_ev(input logic [8:0] x, input logic [8:0] y, input logic p,
                          input logic [47:0] ts, input bit expect_emit, input int max_wait);
      dvs_event_t ev;
      int k;
      ev.x = x; ev.y = y; ev.pol = p; ev.ts = ts;
      in_event = ev;
      in_valid = 1'b1;
      k = 0;
      samp();
      while (in_ready !== 1'b1 && k < max_wait) begin
         tick(1);
         samp();
         k++;
      end
      chk("push_accept", 64'(in_ready), 64'd1);
      if (in_ready === 1'b1) begin
         tick(1);
         if (expect_emit) exp_q.push_back(ev);
      end
      in_valid = 1'b0;
   endtask

   // Wait (bounded) until out_valid is seen; leaves the caller at a negedge
   task automatic wait_valid(input string tag, input int max_cyc);
      int k;
      k = 0;
      samp();
      while (out_valid !== 1'b1 && k < max_cyc) begin
         tick(1);
         samp();
         k++;
      end
      chk(tag, 64'(out_valid), 64'd1);
   endtask

   // Every completed handshake must be the oldest outstanding event, and not early
   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_emit", 64'd1, 64'd0);
         end else begin
            mon_ev = exp_q.pop_front();
            chk("emit_x", 64'(out_x), 64'(mon_ev.x));
            chk("emit_y", 64'(out_y), 64'(mon_ev.y));
            chk("emit_pol", 64'(out_pol), 64'(mon_ev.pol));
            chk("emit_not_early", 64'(now_us >= mon_ev.ts), 64'd1);
         end
      end
   end

   initial begin : main
      bit saw;
      logic [47:0] base;
      int k;

      rst = 1'b1; ts_start = 1'b0; in_event = '0; in_valid = 1'b0; out_ready = 1'b0;

      // Step 1: reset
      tick(3);
      samp();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_now", 64'(now_us), 64'd0);
      chk("rst_late", 64'(late_count), 64'd0);
      tick(1);
      rst = 1'b0;
      samp();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);
      chk("post_rst_out_x", 64'(out_x), 64'd0);

      // Step 2: timed replay of one event
      pulse_ts_start();
      push_ev(9'd345, 9'd259, 1'b1, 48'd3, 1'b1, 10);
      tick(int'(3000 - (cyc - start_cyc)));
      samp();
      chk("t2_now3", 64'(now_us), 64'd3);
      chk("t2_now_model", 64'(now_us), exp_now());
      chk("t2_not_yet", 64'(out_valid), 64'd0);
      tick(1);
      samp();
      chk("t2_valid", 64'(out_valid), 64'd1);
      chk("t2_x", 64'(out_x), 64'd345);
      chk("t2_y", 64'(out_y), 64'd259);
      chk("t2_pol", 64'(out_pol), 64'd1);
      tick(5);
      samp();
      chk("t2_hold_valid", 64'(out_valid), 64'd1);
      chk("t2_hold_x", 64'(out_x), 64'd345);
      tick(1);
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      samp();
      chk("t2_cleared", 64'(out_valid), 64'd0);
      chk("t2_drained", 64'(exp_q.size()), 64'd0);

      // Step 3: time base stopped until ts_start
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      exp_q.delete();
      out_ready = 1'b1;
      push_ev(9'd7, 9'd8, 1'b0, 48'd0, 1'b1, 10);
      saw = 1'b0;
      for (int i = 0; i < 5000; i++) begin
         samp();
         if (out_valid === 1'b1) saw = 1'b1;
         tick(1);
      end
      chk("t3_stopped_no_emit", 64'(saw), 64'd0);
      chk("t3_now_stopped", 64'(now_us), 64'd0);
      pulse_ts_start();
      wait_valid("t3_valid_after_start", 2);
      tick(2);
      chk("t3_drained", 64'(exp_q.size()), 64'd0);

      // Step 4: backpressure fills hold register plus FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++)
         push_ev(9'($urandom), 9'($urandom), 1'($urandom), 48'd0, 1'b1, 10);
      in_event = '0;
      in_valid = 1'b1;
      tick(4);
      samp();
      chk("t4_full_in_ready", 64'(in_ready), 64'd0);
      chk("t4_held_valid", 64'(out_valid), 64'd1);
      tick(1);
      out_ready = 1'b1;
      push_ev(9'd511, 9'd0, 1'b1, 48'd0, 1'b1, 20);
      k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         tick(1);
         k++;
      end
      chk("t4_all_emitted", 64'(exp_q.size()), 64'd0);
      out_ready = 1'b0;

      // Random burst: increasing timestamps, random backpressure
      base = now_us;
      rnd_en = 1'b1;
      for (int i = 0; i < 6; i++)
         push_ev(9'($urandom), 9'($urandom), 1'($urandom), base + 48'(2 + i), 1'b1, 4000);
      k = 0;
      while (exp_q.size() != 0 && k < 12000) begin
         tick(1);
         k++;
      end
      rnd_en = 1'b0;
      out_ready = 1'b0;
      chk("rnd_all_emitted", 64'(exp_q.size()), 64'd0);
      samp();
      chk("rnd_now_model", 64'(now_us), exp_now());
      tick(1);

      // Step 5: late event
      pulse_ts_start();
      tick(int'(10 * US_DIV - (cyc - start_cyc)));
      samp();
      chk("t5_now10", 64'(now_us), 64'd10);
      tick(1);
      out_ready = 1'b1;
`ifdef DVS_LATE_DROP_EN
      push_ev(9'd100, 9'd200, 1'b0, 48'd5, 1'b0, 10);
      saw = 1'b0;
      for (int i = 0; i < 6; i++) begin
         samp();
         if (out_valid === 1'b1) saw = 1'b1;
         tick(1);
      end
      chk("t5_dropped", 64'(saw), 64'd0);
      chk("t5_late_cnt", 64'(late_count), 64'd1);
`else
      push_ev(9'd100, 9'd200, 1'b0, 48'd5, 1'b1, 10);
      wait_valid("t5_late_emitted", 2);
      tick(2);
      chk("t5_late_cnt", 64'(late_count), 64'd0);
`endif
      chk("t5_drained", 64'(exp_q.size()), 64'd0);

      // Step 6: reset while emitting with three events buffered
      out_ready = 1'b0;
      pulse_ts_start();
      for (int i = 0; i < 4; i++)
         push_ev(9'(i + 1), 9'(i + 2), 1'b1, 48'd0, 1'b1, 10);
      wait_valid("t6_emitting", 5);
      tick(1);
      rst = 1'b1;
      tick(1);
      samp();
      chk("t6_rst_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
      tick(1);
      rst = 1'b0;
      samp();
      chk("t6_in_ready", 64'(in_ready), 64'd1);
      chk("t6_now", 64'(now_us), 64'd0);
      tick(1);
      out_ready = 1'b1;
      pulse_ts_start();
      saw = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         samp();
         if (out_valid === 1'b1) saw = 1'b1;
         tick(1);
      end
      chk("t6_no_output_after_rst", 64'(saw), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dvs_event_replayer.md
Name: dvs_event_replayer

Overview:
- Consumer end of the packed DVS event word: reads EVENT_BITS-wide words {x, y, polarity, timestamp_us} and replays each one to the RAVENS side when a local microsecond time base reaches its timestamp.
- Sits downstream of the event packer and upstream of the RAVENS spike input.
- Buffers words in a small FIFO and presents them on a valid/ready port.

Parameters:
FIFO_DEPTH, 4, input FIFO entries; power of two, >=2
US_DIVISOR, CLK_PERIOD_US_DIVISOR (1000), clock cycles per microsecond

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
ts_start  in  1  one-cycle pulse: zero the time base and start it running
in_event  in  EVENT_BITS  packed word: x in MSBs, then y, then polarity, then timestamp in LSBs
in_valid  in  1  in_event valid
in_ready  out  1  FIFO can accept
out_x  out  DVS_X_ADDR_BITS  replayed x address
out_y  out  DVS_Y_ADDR_BITS  replayed y address
out_pol  out  1  replayed polarity
out_valid  out  1  replayed event valid
out_ready  in  1  RAVENS accepts the event
now_us  out  TIMESTAMP_US_BITS  current time base in microseconds
late_count  out  16  dropped-late event count

Behaviour:
- Reset (synchronous, active-high, one clock, clk): values below hold after reset and during reset.
  - Registered outputs cleared: out_valid=0, out_x/out_y/out_pol=0, now_us=0, late_count=0.
  - Internal state cleared: prescaler=0, running=0, FIFO emptied, FSM=IDLE.
  - in_ready = !full && !rst, so it is 0 during reset and 1 after.
- Reset mid-operation discards all buffered and held events; out_valid is low in the cycle after rst is sampled.
- Time base:
  - When running, the prescaler counts 0..US_DIVISOR-1; at US_DIVISOR-1 it wraps to 0 and now_us increments.
  - now_us wraps modulo 2^48; no wrap-aware comparison is performed.
  - ts_start zeroes the prescaler and now_us, then sets running; it also restarts the time base when already running.
  - ts_start leaves the FIFO and FSM untouched.
- Input: a push occurs when in_valid && in_ready. A full FIFO does not accept, even if a pop happens in the same cycle.
- FSM:
  - IDLE: if the FIFO is not empty, pop the head into the hold register; go to WAIT next cycle.
  - WAIT: if running && now_us >= hold.ts, register the fields onto out_*, set out_valid, go to EMIT. Otherwise stay.
  - EMIT: out_valid and out_* stay stable until out_ready. On out_valid && out_ready, clear out_valid and go to IDLE.
- Latency: an event accepted at cycle N into an empty FIFO, with ts <= now_us, is popped at N+1 and has out_valid=1 at N+2.
- Events are emitted in arrival order. A smaller timestamp behind a larger one waits behind it (no reordering).

Optional Feature:
- DVS_LATE_DROP_EN defined:
  - In WAIT, when running && hold.ts < now_us in the first WAIT cycle, the event is discarded with no out_valid.
  - late_count increments and saturates at 16'hFFFF; FSM returns to IDLE.
- DVS_LATE_DROP_EN undefined:
  - Late events are emitted immediately.
  - late_count stays 0 and the port remains present.

Decomposition:
- Additions to dvs_ravens_pkg:
  - typedef dvs_event_t: packed struct {x, y, pol, ts} matching the EVENT_BITS layout.
  - replay FSM enum typedef.
  - LATE_CNT_BITS=16.
- Sub-module: dvs_event_fifo, a synchronous FIFO with parameters DEPTH and WIDTH, ports push/pop/full/empty, reset-clearable pointers.

Test Plan:
1. Assert rst 3 cycles, then release -> out_valid=0, now_us=0, late_count=0, in_ready=0 during reset and 1 after.
2. ts_start, then push x=345, y=259, pol=1, ts=3 -> now_us=3 after 3000 running cycles; out_valid within 1 cycle of that, carrying x=345, y=259, pol=1; cleared the cycle after out_ready.
3. No ts_start; push ts=0 -> out_valid stays 0 for 5000 cycles; pulse ts_start -> out_valid within 2 cycles.
4. Running, out_ready=0, push 6 events with ts=0 (DEPTH 4) -> in_ready drops after 5 accepts (1 held + 4 buffered); raise out_ready -> all 5 emitted in order, then the 6th is accepted.
5. now_us=10, push ts=5:
   - with DVS_LATE_DROP_EN -> no out_valid, late_count=1;
   - without it -> emitted within 2 cycles, late_count=0.
6. Assert rst while in EMIT with 3 events buffered -> out_valid=0 next cycle, FIFO empty, no further outputs after release.
